// File: rtl/tx_clk_pkg.sv
// tx_clk_pkg: shared state type, rate codes and divider helper for the tx rate enable generator
package tx_clk_pkg;
  typedef enum logic [1:0] {OFF, RUN, DRAIN, GAP} tx_rate_state_t;
  localparam int RATE_OFF = 0;
  localparam int RATE_DIV4 = 1;
  localparam int RATE_DIV2 = 2;
  localparam int RATE_DIV1 = 3;
  function automatic int div_from_code(input int code, input int num_rates);
    return (code == RATE_OFF || code > num_rates) ? 1 : 1 << (num_rates - code);
  endfunction
endpackage

// File: rtl/tx_rate_divcnt.sv
// tx_rate_divcnt: divide counter that wraps at div_m1 and clears to 0 while not running
module tx_rate_divcnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] div_m1,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         tc
);
  assign tc = cnt == div_m1;
  assign cnt_nxt = run ? (tc ? '0 : cnt + 1'b1) : '0;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : cnt_nxt;
endmodule

// File: rtl/tx_rate_clken_gen.sv
// tx_rate_clken_gen: per-rate clock enables from the fastest tx clock with drain+gap rate switching.
// Define TX_RATE_SWITCH_CNT_EN to add the saturating switch_cnt output.
module tx_rate_clken_gen
  import tx_clk_pkg::*;
#(
  parameter int NUM_RATES = 3,
  parameter int RATE_W = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_TDPU,
  input  logic [RATE_W-1:0] txRate,
  output logic              clk_en,
  output logic              clk_phase,
  output logic [RATE_W-1:0] rate_active,
  output logic              switching,
  output logic              rate_err
`ifdef TX_RATE_SWITCH_CNT_EN
  ,
  output logic [15:0]       switch_cnt
`endif
);
  localparam int CNT_W = NUM_RATES > 2 ? NUM_RATES - 1 : 1;
  localparam logic [RATE_W-1:0] MAX_CODE = RATE_W'(NUM_RATES);
  tx_rate_state_t state, nxt_state;
  logic [RATE_W-1:0] sel_q;
  logic [3:0] gap_cnt;
  logic [CNT_W-1:0] cnt, cnt_nxt, div_m1;
  logic tc, gap_end, en_nxt;
  assign div_m1 = CNT_W'(div_from_code(int'(rate_active), NUM_RATES) - 1);
  assign gap_end = gap_cnt == 4'(GAP_CYCLES - 1);
  tx_rate_divcnt #(.W(CNT_W)) u_divcnt (
    .clk    (clk),
    .rst    (rst),
    .run    (state == RUN || state == DRAIN),
    .div_m1 (div_m1),
    .cnt    (cnt),
    .cnt_nxt(cnt_nxt),
    .tc     (tc)
  );
  always_comb begin
    nxt_state = state;
    case (state)
      OFF:     nxt_state = sel_q != '0 ? GAP : OFF;
      RUN:     nxt_state = sel_q != rate_active ? DRAIN : RUN;
      DRAIN:   nxt_state = tc ? GAP : DRAIN;
      default: nxt_state = gap_end ? (sel_q != '0 ? RUN : OFF) : GAP;
    endcase
  end
  // Outputs are registered from next-state so they line up with the state they describe
  assign en_nxt = (nxt_state == RUN || nxt_state == DRAIN) && cnt_nxt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OFF;
      sel_q       <= '0;
      rate_err    <= 1'b0;
      gap_cnt     <= '0;
      rate_active <= '0;
      clk_en      <= 1'b0;
      clk_phase   <= 1'b0;
      switching   <= 1'b0;
    end else begin
      state       <= nxt_state;
      sel_q       <= (en_TDPU && txRate != '0 && txRate <= MAX_CODE) ? txRate : '0;
      rate_err    <= en_TDPU && txRate > MAX_CODE;
      gap_cnt     <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
      rate_active <= (state == GAP && gap_end) ? sel_q : rate_active;
      clk_en      <= en_nxt;
      clk_phase   <= clk_phase ^ en_nxt;
      switching   <= nxt_state == DRAIN || nxt_state == GAP;
    end
  end
`ifdef TX_RATE_SWITCH_CNT_EN
  always_ff @(posedge clk)
    if (rst) switch_cnt <= '0;
    else if (state == GAP && gap_end && switch_cnt != 16'hFFFF) switch_cnt <= switch_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_tx_rate_clken_gen.sv
// tb_tx_rate_clken_gen: directed checks of enables, rate switching, invalid codes and reset
module tb_tx_rate_clken_gen;
  logic clk = 1'b0;
  logic rst, en_TDPU, clk_en, clk_phase, switching, rate_err;
  logic [2:0] txRate, rate_active;
`ifdef TX_RATE_SWITCH_CNT_EN
  logic [15:0] switch_cnt;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tx_rate_clken_gen #(.NUM_RATES(3), .RATE_W(3), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_TDPU    (en_TDPU),
    .txRate     (txRate),
    .clk_en     (clk_en),
    .clk_phase  (clk_phase),
    .rate_active(rate_active),
    .switching  (switching),
    .rate_err   (rate_err)
`ifdef TX_RATE_SWITCH_CNT_EN
    ,
    .switch_cnt (switch_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic e, input logic s, input logic [2:0] r);
    tick();
    chk({tag, ".clk_en"}, 16'(clk_en), 16'(e));
    chk({tag, ".switching"}, 16'(switching), 16'(s));
    chk({tag, ".rate_active"}, 16'(rate_active), 16'(r));
  endtask
  initial begin
    rst = 1'b1;
    en_TDPU = 1'b0;
    txRate = 3'd0;
    repeat (3) tick();
    chk("rst.clk_en", 16'(clk_en), 16'd0);
    chk("rst.clk_phase", 16'(clk_phase), 16'd0);
    chk("rst.rate_active", 16'(rate_active), 16'd0);
    chk("rst.switching", 16'(switching), 16'd0);
    chk("rst.rate_err", 16'(rate_err), 16'd0);
    rst = 1'b0;
    tick();
    en_TDPU = 1'b1;
    txRate = 3'd3;
    outs("e1", 0, 0, 0);
    outs("e2", 0, 1, 0);
    outs("e3", 0, 1, 0);
    outs("e4", 1, 0, 3);
    chk("e4.clk_phase", 16'(clk_phase), 16'd1);
    outs("e5", 1, 0, 3);
    chk("e5.clk_phase", 16'(clk_phase), 16'd0);
    outs("e6", 1, 0, 3);
    // 3 -> 1: single-cycle drain at div 1, then 2 quiet cycles
    txRate = 3'd1;
    outs("e7", 1, 0, 3);
    outs("e8", 1, 1, 3);
    outs("e9", 0, 1, 3);
    outs("e10", 0, 1, 3);
    outs("e11", 1, 0, 1);
    chk("e11.clk_phase", 16'(clk_phase), 16'd0);
    outs("e12", 0, 0, 1);
    outs("e13", 0, 0, 1);
    // 1 -> 2 requested mid-period: drain keeps the cnt==0 enable and runs to cnt==3
    txRate = 3'd2;
    outs("e14", 0, 0, 1);
    outs("e15", 1, 1, 1);
    outs("e16", 0, 1, 1);
    outs("e17", 0, 1, 1);
    outs("e18", 0, 1, 1);
    outs("e19", 0, 1, 1);
    outs("e20", 0, 1, 1);
    outs("e21", 1, 0, 2);
    outs("e22", 0, 0, 2);
    outs("e23", 1, 0, 2);
    // request 1, then 3 during gap, then 2 on the final gap cycle
    txRate = 3'd1;
    outs("e24", 0, 0, 2);
    outs("e25", 1, 1, 2);
    outs("e26", 0, 1, 2);
    txRate = 3'd3;
    outs("e27", 0, 1, 2);
    txRate = 3'd2;
    outs("e28", 0, 1, 2);
    outs("e29", 1, 0, 2);
    outs("e30", 0, 0, 2);
    outs("e31", 1, 0, 2);
    chk("e31.rate_err", 16'(rate_err), 16'd0);
    // invalid code drains to off
    txRate = 3'd5;
    outs("e32", 0, 0, 2);
    chk("e32.rate_err", 16'(rate_err), 16'd1);
    outs("e33", 1, 1, 2);
    outs("e34", 0, 1, 2);
    outs("e35", 0, 1, 2);
    outs("e36", 0, 1, 2);
    outs("e37", 0, 0, 0);
    chk("e37.rate_err", 16'(rate_err), 16'd1);
    chk("e37.clk_phase", 16'(clk_phase), 16'd1);
`ifdef TX_RATE_SWITCH_CNT_EN
    chk("e37.switch_cnt", switch_cnt, 16'd5);
`endif
    outs("e38", 0, 0, 0);
    en_TDPU = 1'b0;
    tick();
    chk("e39.rate_err", 16'(rate_err), 16'd0);
    // reset in the middle of a gap
    en_TDPU = 1'b1;
    txRate = 3'd3;
    outs("e40", 0, 0, 0);
    outs("e41", 0, 1, 0);
    rst = 1'b1;
    outs("e42", 0, 0, 0);
    chk("e42.clk_phase", 16'(clk_phase), 16'd0);
    chk("e42.rate_err", 16'(rate_err), 16'd0);
`ifdef TX_RATE_SWITCH_CNT_EN
    chk("e42.switch_cnt", switch_cnt, 16'd0);
`endif
    outs("e43", 0, 0, 0);
    rst = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
